// File: rtl/nv_nvdla_sdp_mrdma_cq_param.sv
// Parametrised MRDMA context queue between the ingress (ig) and egress (eg) engines.
// Flop-array storage with a registered output stage, a runtime write limit,
// a programmable almost-full flag, an occupancy output and a synchronous flush.
//
// Ports:
//   nvdla_core_clk / nvdla_core_rstn : clock, async active-low reset
//   ig2cq_pvld / ig2cq_prdy / ig2cq_pd : write handshake (prdy registered)
//   cq2eg_pvld / cq2eg_prdy / cq2eg_pd : read handshake (pvld, pd registered)
//   cfg_wr_limit     : 0 = DEPTH, else max occupancy accepted
//   cfg_afull_thresh : 0 = afull disabled, else afull level
//   cq_flush         : synchronous flush, discards all content
//   cq_count / cq_afull : registered occupancy and almost-full flag
module nv_nvdla_sdp_mrdma_cq_param #(
    parameter int unsigned WIDTH = 14,
    parameter int unsigned DEPTH = 80,
    parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic             nvdla_core_clk,
    input  logic             nvdla_core_rstn,
    input  logic             ig2cq_pvld,
    output logic             ig2cq_prdy,
    input  logic [WIDTH-1:0] ig2cq_pd,
    output logic             cq2eg_pvld,
    input  logic             cq2eg_prdy,
    output logic [WIDTH-1:0] cq2eg_pd,
    input  logic [CW-1:0]    cfg_wr_limit,
    input  logic [CW-1:0]    cfg_afull_thresh,
    input  logic             cq_flush,
    output logic [CW-1:0]    cq_count,
    output logic             cq_afull
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    // Entries in the array that may be moved into the output stage. A freshly
    // written entry becomes eligible one cycle later (push_q), giving the
    // two-cycle write-to-output latency.
    logic [CW-1:0]    elig_q, elig_d;
    logic             push_q, push_d;
    logic             prdy_q, prdy_d;
    logic             pvld_q, pvld_d;
    logic [WIDTH-1:0] pd_q, pd_d;
    logic             afull_q, afull_d;

    logic             push_c, pop_c, load_c;
    logic [CW-1:0]    eff_limit_c;

    // Pointer increment with wrap for arbitrary DEPTH.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Next-state logic.
    always_comb begin
        push_c      = ig2cq_pvld && prdy_q && !cq_flush;
        pop_c       = pvld_q && cq2eg_prdy;
        load_c      = (elig_q != '0) && (!pvld_q || pop_c) && !cq_flush;
        eff_limit_c = ((cfg_wr_limit == '0) || (cfg_wr_limit > CW'(DEPTH))) ? CW'(DEPTH) : cfg_wr_limit;

        wr_ptr_d = push_c ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = load_c ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q + CW'(push_c) - CW'(pop_c);
        elig_d   = elig_q - CW'(load_c) + CW'(push_q);
        push_d   = push_c;
        pd_d     = load_c ? mem_q[rd_ptr_q] : pd_q;
        pvld_d   = load_c ? 1'b1 : (pop_c ? 1'b0 : pvld_q);

        if (cq_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            elig_d   = '0;
            push_d   = 1'b0;
            pvld_d   = 1'b0;
        end

        prdy_d  = !(count_d >= eff_limit_c);
        afull_d = (cfg_afull_thresh != '0) && (count_d >= cfg_afull_thresh);
    end

    // State registers.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            elig_q   <= '0;
            push_q   <= 1'b0;
            prdy_q   <= 1'b1;
            pvld_q   <= 1'b0;
            pd_q     <= '0;
            afull_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            elig_q   <= elig_d;
            push_q   <= push_d;
            prdy_q   <= prdy_d;
            pvld_q   <= pvld_d;
            pd_q     <= pd_d;
            afull_q  <= afull_d;
        end
    end

    // Storage array.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_c) begin
            mem_q[wr_ptr_q] <= ig2cq_pd;
        end
    end

    assign ig2cq_prdy = prdy_q;
    assign cq2eg_pvld = pvld_q;
    assign cq2eg_pd   = pd_q;
    assign cq_count   = count_q;
    assign cq_afull   = afull_q;

endmodule

// File: tb/tb_nv_nvdla_sdp_mrdma_cq_param.sv
// Self-checking bench for nv_nvdla_sdp_mrdma_cq_param (WIDTH=14, DEPTH=80).
// Reference model: a queue of (data, push cycle) entries; the head is visible
// once it has been resident for two edges. A separate scoreboard queue holds
// the accepted data and is drained by a monitor on every output handshake.
module tb_nv_nvdla_sdp_mrdma_cq_param;

    localparam int WIDTH = 14;
    localparam int DEPTH = 80;
    localparam int CW    = 7;

    logic             clk;
    logic             rstn;
    logic             pvld_in;
    logic             prdy_out;
    logic [WIDTH-1:0] pd_in;
    logic             pvld_out;
    logic             rdy_in;
    logic [WIDTH-1:0] pd_out;
    logic [CW-1:0]    lim;
    logic [CW-1:0]    thr;
    logic             flush_in;
    logic [CW-1:0]    count_out;
    logic             afull_out;

    nv_nvdla_sdp_mrdma_cq_param #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .nvdla_core_clk  (clk),
        .nvdla_core_rstn (rstn),
        .ig2cq_pvld      (pvld_in),
        .ig2cq_prdy      (prdy_out),
        .ig2cq_pd        (pd_in),
        .cq2eg_pvld      (pvld_out),
        .cq2eg_prdy      (rdy_in),
        .cq2eg_pd        (pd_out),
        .cfg_wr_limit    (lim),
        .cfg_afull_thresh(thr),
        .cq_flush        (flush_in),
        .cq_count        (count_out),
        .cq_afull        (afull_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] d;
        int               e;
    } ent_t;

    ent_t             mq[$];
    logic [WIDTH-1:0] exp_q[$];
    int               cyc;
    int               m_cnt;
    bit               m_prdy, m_pvld, m_afull;
    int               errors = 0;
    int               checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model, updated on every active edge from the driven inputs.
    always @(posedge clk) begin
        if (!rstn) begin
            mq.delete();
            exp_q.delete();
            cyc     = 0;
            m_cnt   = 0;
            m_prdy  = 1'b1;
            m_pvld  = 1'b0;
            m_afull = 1'b0;
        end else begin
            bit pop_m, push_m;
            int eff;
            cyc++;
            pop_m  = m_pvld && rdy_in;
            push_m = pvld_in && m_prdy && !flush_in;
            if (flush_in) begin
                mq.delete();
                exp_q.delete();
            end else begin
                if (pop_m) void'(mq.pop_front());
                if (push_m) begin
                    mq.push_back('{pd_in, cyc});
                    exp_q.push_back(pd_in);
                end
            end
            eff     = (lim == 0 || int'(lim) > DEPTH) ? DEPTH : int'(lim);
            m_cnt   = mq.size();
            m_prdy  = !(m_cnt >= eff);
            m_afull = (thr != 0) && (m_cnt >= int'(thr));
            m_pvld  = (mq.size() > 0) && (mq[0].e <= cyc - 2);
        end
    end

    // Monitor: compares DUT state to the model and pops the scoreboard.
    always @(negedge clk) begin
        if (rstn) begin
            chk("count", int'(count_out), m_cnt);
            chk("prdy", int'(prdy_out), int'(m_prdy));
            chk("pvld", int'(pvld_out), int'(m_pvld));
            chk("afull", int'(afull_out), int'(m_afull));
            if (m_pvld && mq.size() > 0) chk("head_pd", int'(pd_out), int'(mq[0].d));
            if (pvld_out && rdy_in) begin
                if (exp_q.size() == 0) begin
                    chk("sb_nonempty", 0, 1);
                end else begin
                    logic [WIDTH-1:0] e;
                    e = exp_q.pop_front();
                    chk("sb_data", int'(pd_out), int'(e));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_n(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            pvld_in = 1'b1;
            pd_in   = WIDTH'(base + i);
            tick();
        end
        pvld_in = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        pvld_in = 1'b0;
        rdy_in  = 1'b1;
        while (count_out != 0 && n < 1000) begin
            tick();
            n++;
        end
        chk("drain_done", int'(count_out), 0);
        repeat (2) tick();
    endtask

    initial begin
        rstn = 1'b0; pvld_in = 1'b0; pd_in = '0; rdy_in = 1'b0;
        lim = '0; thr = '0; flush_in = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_prdy", int'(prdy_out), 1);
        chk("rst_pvld", int'(pvld_out), 0);
        chk("rst_pd", int'(pd_out), 0);
        chk("rst_count", int'(count_out), 0);
        chk("rst_afull", int'(afull_out), 0);
        @(posedge clk);
        #1 rstn = 1'b1;
        tick();

        // Single write, two-cycle latency, popped immediately.
        rdy_in = 1'b1;
        push_n(1, 'h2A5);
        repeat (5) tick();

        // Fill to DEPTH with egress stalled, two extra writes must be ignored.
        rdy_in = 1'b0;
        push_n(80, 0);
        push_n(2, 'h3FFF);
        tick();
        rdy_in = 1'b1;
        tick();
        rdy_in = 1'b0;
        repeat (2) tick();
        drain();

        // Stream 300 incrementing words with random egress backpressure.
        begin
            int w = 0;
            int n = 0;
            bit acc;
            while (w < 300 && n < 5000) begin
                pvld_in = 1'b1;
                pd_in   = WIDTH'(w);
                rdy_in  = ($urandom_range(0, 3) != 0);
                @(negedge clk);
                acc = prdy_out;
                tick();
                if (acc) w++;
                n++;
            end
            chk("stream_done", w, 300);
        end
        drain();

        // Runtime write limit, then back to DEPTH.
        rdy_in = 1'b0;
        lim = CW'(5);
        push_n(7, 'h100);
        tick();
        lim = '0;
        push_n(80, 'h200);
        tick();
        drain();

        // Almost-full at 60, then disabled at full.
        thr = CW'(60);
        rdy_in = 1'b0;
        push_n(61, 'h300);
        rdy_in = 1'b1;
        repeat (2) tick();
        rdy_in = 1'b0;
        repeat (2) tick();
        thr = '0;
        push_n(30, 'h400);
        tick();
        drain();

        // Flush with a concurrent write, then a single write.
        rdy_in = 1'b0;
        push_n(40, 'h500);
        repeat (3) tick();
        flush_in = 1'b1;
        pvld_in  = 1'b1;
        pd_in    = WIDTH'('h2222);
        tick();
        flush_in = 1'b0;
        pvld_in  = 1'b0;
        tick();
        push_n(1, 'h111);
        repeat (4) tick();
        drain();

        // Randomised mix including config changes and rare flushes.
        for (int i = 0; i < 1500; i++) begin
            if (i % 200 == 0) begin
                lim = CW'($urandom_range(0, 90));
                thr = CW'($urandom_range(0, 80));
            end
            pvld_in  = ($urandom_range(0, 1) != 0);
            pd_in    = WIDTH'($urandom);
            rdy_in   = ($urandom_range(0, 2) != 0);
            flush_in = ($urandom_range(0, 63) == 0);
            tick();
        end
        flush_in = 1'b0;
        lim = '0;
        thr = '0;
        drain();
        chk("sb_empty_end", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/nv_nvdla_sdp_mrdma_cq_param.md
Name: nv_nvdla_sdp_mrdma_cq_param

Overview:
Parametrised synchronous context queue for the SDP MRDMA ingress-to-egress path. It is the successor of the fixed 80x14 command queue.
- Width and depth are parameters; depth need not be a power of two.
- Adds a runtime write limit, a programmable almost-full flag, an occupancy output and a synchronous flush.
- Sits between the MRDMA ingress (ig) and egress (eg) engines on nvdla_core_clk. Flop-array storage, no RAM macro.

Parameters:
WIDTH, 14, payload bits per entry
DEPTH, 80, entry count (2..256, any integer)
CW, $clog2(DEPTH+1), width of count/limit/threshold fields (7 for default)

Ports:
nvdla_core_clk  in  1  core clock
nvdla_core_rstn  in  1  reset, asynchronous assert, active-low
ig2cq_pvld  in  1  write valid
ig2cq_prdy  out  1  write ready (registered)
ig2cq_pd  in  WIDTH  write payload
cq2eg_pvld  out  1  read valid (registered)
cq2eg_prdy  in  1  read ready
cq2eg_pd  out  WIDTH  read payload (registered)
cfg_wr_limit  in  CW  0 = use DEPTH; else max occupancy allowed
cfg_afull_thresh  in  CW  0 = afull disabled; else afull level
cq_flush  in  1  synchronous flush pulse
cq_count  out  CW  current occupancy (registered)
cq_afull  out  1  almost-full flag (registered)

Behaviour:
- One clock; reset is asynchronous and active-low on nvdla_core_rstn. All state is cleared during reset.
- Reset values:
  - ig2cq_prdy=1 (a reset-time value of 0 is also acceptable, provided it rises on the first edge after reset release).
  - cq2eg_pvld=0, cq2eg_pd=0, cq_count=0, cq_afull=0.
  - Write and read pointers are 0.
- push = ig2cq_pvld && ig2cq_prdy && !cq_flush. pop = cq2eg_pvld && cq2eg_prdy.
- ig2cq_pvld while prdy=0 has no effect: no write, no error.
- Occupancy counts every accepted, unpopped entry, including the one presented on cq2eg.
  - count_next = count + push - pop. Push and pop in the same cycle leave it unchanged.
- Ready rule: eff_limit = (cfg_wr_limit==0 || cfg_wr_limit>DEPTH) ? DEPTH : cfg_wr_limit.
  - ig2cq_prdy_next = !(count_next >= eff_limit).
  - prdy is registered, so it deasserts on the edge that makes occupancy reach the limit. It never accepts beyond DEPTH.
- Lowering cfg_wr_limit below the current count: prdy drops on the next edge. No stored entries are lost.
- Pointers advance by 1 per push/pop and wrap from DEPTH-1 to 0. Wrap is required for non-power-of-two DEPTH.
- Latency:
  - A push into an empty queue at edge E0 gives cq2eg_pvld=1 with that data after edge E2 (two cycles).
  - Sustained throughput is 1 entry/cycle. With entries already resident, consecutive pops produce no bubbles.
- Output hold: while cq2eg_pvld=1 and cq2eg_prdy=0, cq2eg_pd and cq2eg_pvld are stable. The only exception is flush.
- Ordering is strict FIFO and there is no data loss, except on flush.
- cq_afull_next = (cfg_afull_thresh!=0) && (count_next >= cfg_afull_thresh). It is updated every cycle.
- Flush (cq_flush=1 for one or more cycles):
  - Any write presented in that cycle is discarded.
  - After the edge: count=0, both pointers=0, cq2eg_pvld=0, cq_afull=0, ig2cq_prdy=1.
  - In-flight reads are cancelled.
  - Flush wins over a simultaneous pop; the pop is still considered consumed by egress.
  - Normal operation resumes on the cycle after cq_flush falls.
- Config inputs are sampled every cycle and need not be static, but changes are only guaranteed glitch-free in their effect when the queue is idle.
- Fill timing: when count_next reaches DEPTH, prdy=0 takes effect on the following cycle. The entry just stored is retained.
- After a pop at full, prdy returns 1 after that edge. A push on the next cycle is accepted.

Test Plan:
- Reset then single write 0x2A5 at edge E0 -> cq2eg_pvld=1, pd=0x2A5 after E2; cq_count=1 after E0; pop -> count 0, pvld 0 next cycle.
- Fill with prdy held 0 on egress, data 0..79 -> prdy=0 after 80th push, cq_count=80, 81st write ignored; pop one -> prdy=1 next cycle, first pd=0.
- Continuous push+pop of 300 incrementing words with random cq2eg_prdy -> output sequence identical 0..299, pointer wraps past 79 at least 3 times, count never exceeds 80.
- cfg_wr_limit=5, egress stalled -> prdy drops after 5th push, cq_count=5; set limit 0 -> prdy rises next cycle, fills to 80.
- cfg_afull_thresh=60 -> cq_afull rises on edge count reaches 60, falls on edge count drops to 59; thresh 0 -> afull stays 0 at full.
- Queue holding 40 entries, pvld=1 and stalled; assert cq_flush one cycle with concurrent write -> next cycle count=0, pvld=0, prdy=1; subsequent write 0x111 emerges after two cycles as sole entry.
